uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side UART front end. Deserialises the asynchronous line from the FTDI bridge (8N1, LSB first) and buffers received bytes in a small FIFO. Bytes are presented to the downstream UART/core logic on a valid/ready stream. Sits between the board pin ftdi_txd and the byte consumer inside Uart.

Parameters:
CLKS_PER_BIT, 217, clock cycles per bit (25 MHz / 115200); must be >= 4.
FIFO_DEPTH, 8, byte entries in the receive FIFO; power of two, >= 2.

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_rx  in  1  raw serial line, idle high, asynchronous to clock
out_valid  out  1  FIFO non-empty; out_data holds the oldest byte
out_data  out  8  oldest received byte (first-word-fall-through)
out_ready  in  1  consumer accepts the byte when out_valid && out_ready
out_frame_err  out  1  one-cycle pulse: stop bit sampled low, byte discarded
out_overrun  out  1  one-cycle pulse: byte completed while FIFO full, byte discarded
out_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: out_valid=0, out_data=0, out_frame_err=0, out_overrun=0, out_count=0. Synchroniser flops reset to 1 (idle). FSM resets to IDLE. Reset asserted mid-frame abandons the frame and empties the FIFO.
- in_rx passes through a 2-flop synchroniser; rx_s is the second-flop output. All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP. Bit counter 0..7; baud counter 0..CLKS_PER_BIT-1.
- IDLE: when rx_s==0, go to START and load the baud counter for CLKS_PER_BIT/2 (integer division).
- START: when the half-bit count expires, sample rx_s. If 1 (glitch), return to IDLE with no pulse. If 0, go to DATA and reload the counter for CLKS_PER_BIT.
- DATA: on each full-bit expiry, shift rx_s into the MSB of the shift register (LSB-first reconstruction). After the 8th sample, go to STOP.
- STOP: on full-bit expiry, sample rx_s.
  - If 1: push the byte into the FIFO.
  - If 0: pulse out_frame_err for 1 cycle and discard the byte.
  - In both cases return to IDLE that same cycle, i.e. at mid-stop-bit, so a start bit that immediately follows is caught.
- Latency: the byte is visible on out_valid/out_data the cycle after the stop-bit sample.
- FIFO:
  - Pop occurs on out_valid && out_ready.
  - A push when full and not popping in the same cycle is dropped and pulses out_overrun for 1 cycle. The stored contents are unchanged.
  - Push and pop in the same cycle when full: both succeed and count is unchanged.
  - Push and pop in the same cycle when empty: the pushed byte is stored and appears next cycle. No bypass, because out_valid was 0.
  - Pointers wrap modulo FIFO_DEPTH. out_count = write pointer minus read pointer, computed with an extra wrap bit.
- out_ready asserted while out_valid=0 has no effect.
- No parity, no break detection. A line held low longer than one frame produces one frame_err, then waits in IDLE for rx_s to rise and fall again. To enforce this, IDLE arms only after rx_s has been seen high.

Decomposition:
- Shared package uart_pkg holds:
  - rx state enum (IDLE/START/DATA/STOP)
  - DATA_BITS=8
  - the default CLKS_PER_BIT constant, also used by the TX side
- Sub-module sync_fifo: parameterised width/depth, FWFT, with push/pop/full/empty/count. It is reusable by the TX path.

Test Plan:
All scenarios run with CLKS_PER_BIT=16 and FIFO_DEPTH=4.
- Single frame: send 0xA5 (LSB first, 8N1), out_ready=1 -> out_valid pulses with out_data=0xA5 about 2+16*9.5 cycles after the start edge; no error pulses.
- Glitch: drive in_rx low for 5 cycles, then high -> FSM returns to IDLE, out_valid stays 0, no frame_err.
- Framing error: send 0x3C with stop bit = 0 -> out_frame_err pulses for exactly 1 cycle; out_count stays 0. Next valid frame 0x11 is received correctly.
- Overrun: with out_ready=0, send 0x01..0x05 back-to-back -> out_count reaches 4 and out_overrun pulses once on the 5th byte. Raising out_ready then drains 0x01,0x02,0x03,0x04 in order.
- Simultaneous push/pop at full: FIFO full, pop asserted in the stop-sample cycle of byte 0x77 -> no overrun, out_count stays 4, 0x77 emerges last.
- Reset mid-frame: assert reset during the DATA bit 3 of a frame with 2 bytes queued -> next cycle out_valid=0 and out_count=0. The following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and the receive state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 217;   // 25 MHz / 115200 baud

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Received-byte stream plus status pulses and FIFO occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    import uart_pkg::*;

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    logic                 out_valid;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_ready;
    logic                 out_frame_err;
    logic                 out_overrun;
    logic [c_cnt_w-1:0]   out_count;

    modport master (
        output out_valid, out_data, out_frame_err, out_overrun, out_count,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_frame_err, out_overrun, out_count,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO with wrap-bit pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire                     clk,
    input  wire                     rst,
    input  wire                     i_push,
    input  wire  [WIDTH-1:0]        i_data,
    input  wire                     i_pop,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_pop;
    logic             w_push;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Full when the low bits match but the wrap bits differ
    assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver with mid-bit sampling feeding a byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  wire            clock,
    input  wire            reset,
    input  wire            in_rx,
    uart_rx_fifo_if.master rx_if
);

    localparam int                  c_baud_w      = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_full_reload = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_half_reload = c_baud_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]          c_last_bit    = 3'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_rx_s;
    rx_state_t            r_state;
    logic [c_baud_w-1:0]  r_baud_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_armed;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= in_rx;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_tick = (r_baud_cnt == '0);
    assign w_push = (r_state == RX_STOP) && w_tick && r_rx_s;
    assign w_pop  = rx_if.out_ready && !w_empty;

    // r_armed blocks a new start until the line has been seen idle-high,
    // so a stuck-low line yields a single frame error rather than a stream.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= RX_IDLE;
            r_baud_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= w_push && w_full && !w_pop;
            case (r_state)
                RX_IDLE: begin
                    if (!r_rx_s && r_armed) begin
                        r_state    <= RX_START;
                        r_baud_cnt <= c_half_reload;
                        r_armed    <= 1'b0;
                    end else if (r_rx_s) begin
                        r_armed    <= 1'b1;
                    end
                end
                RX_START: begin
                    if (!w_tick) begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end else if (r_rx_s) begin
                        r_state    <= RX_IDLE;
                        r_armed    <= 1'b1;
                    end else begin
                        r_state    <= RX_DATA;
                        r_baud_cnt <= c_full_reload;
                        r_bit_cnt  <= '0;
                    end
                end
                RX_DATA: begin
                    if (!w_tick) begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end else begin
                        r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        r_baud_cnt <= c_full_reload;
                        if (r_bit_cnt == c_last_bit) r_state   <= RX_STOP;
                        else                         r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge is caught
                    if (!w_tick) begin
                        r_baud_cnt  <= r_baud_cnt - 1'b1;
                    end else begin
                        r_state     <= RX_IDLE;
                        r_armed     <= r_rx_s;
                        r_frame_err <= !r_rx_s;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (r_shift),
        .i_pop   (w_pop),
        .o_data  (rx_if.out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (rx_if.out_count)
    );

    assign rx_if.out_valid     = !w_empty;
    assign rx_if.out_frame_err = r_frame_err;
    assign rx_if.out_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Scoreboard bench: serial frames in, byte stream checked against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic in_rx = 1'b1;

    int n_tests  = 0;
    int n_fail   = 0;
    int exp_ferr = 0;
    int exp_ovr  = 0;
    int seen_ferr = 0;
    int seen_ovr  = 0;
    logic [7:0] exp_q [$];

    always #5 clock = ~clock;

    uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) rx_if ();

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .in_rx (in_rx),
        .rx_if (rx_if)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: occupancy, valid and head-of-queue data every cycle; pop on handshake
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_if.out_frame_err) seen_ferr++;
            if (rx_if.out_overrun)   seen_ovr++;
            check("count", 32'(rx_if.out_count), 32'(exp_q.size()));
            check("valid", 32'(rx_if.out_valid), 32'(exp_q.size() != 0));
            if (rx_if.out_valid && exp_q.size() != 0) begin
                check("data", 32'(rx_if.out_data), 32'(exp_q[0]));
                if (rx_if.out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Line model: each bit lasts CPB cycles. The receiver sees the line two
    // cycles late and notices the start one cycle after that, so the stop bit
    // is judged 3 + CPB/2 + 9*CPB edges after the start bit is driven.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pulse_ready);
        in_rx = 1'b0;
        repeat (CPB) @(posedge clock);
        #1;
        for (int i = 0; i < 8; i++) begin
            in_rx = b[i];
            repeat (CPB) @(posedge clock);
            #1;
        end
        in_rx = stop_bit;
        repeat (3 + CPB / 2 - 1) @(posedge clock);
        #1;
        if (pulse_ready) rx_if.out_ready = 1'b1;
        @(posedge clock);
        #1;
        if (pulse_ready) rx_if.out_ready = 1'b0;
        if (!stop_bit)                  exp_ferr++;
        else if (exp_q.size() < DEPTH)  exp_q.push_back(b);
        else                            exp_ovr++;
        repeat (CPB - 3 - CPB / 2) @(posedge clock);
        #1;
        in_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain_and_check(input string tag);
        int guard;
        guard = 0;
        rx_if.out_ready = 1'b1;
        while (rx_if.out_count != 0 && guard < 100) begin
            idle(1);
            guard++;
        end
        idle(2);
        check({tag, "_drained"}, 32'(rx_if.out_count), 32'd0);
        check({tag, "_ferr"},    32'(seen_ferr),       32'(exp_ferr));
        check({tag, "_ovr"},     32'(seen_ovr),        32'(exp_ovr));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        logic       rgood;
        int         gap;
        int         ferr0;
        int         ovr0;

        rx_if.out_ready = 1'b0;
        idle(3);
        reset = 1'b0;
        check("rst_valid", 32'(rx_if.out_valid),     32'd0);
        check("rst_data",  32'(rx_if.out_data),      32'd0);
        check("rst_ferr",  32'(rx_if.out_frame_err), 32'd0);
        check("rst_ovr",   32'(rx_if.out_overrun),   32'd0);
        check("rst_count", 32'(rx_if.out_count),     32'd0);
        idle(5);

        // Single frame
        rx_if.out_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        drain_and_check("single");

        // Short glitch on the line
        in_rx = 1'b0;
        idle(5);
        in_rx = 1'b1;
        idle(30);
        drain_and_check("glitch");

        // Framing error then a clean frame
        ferr0 = seen_ferr;
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(4);
        check("ferr_one_cycle", 32'(seen_ferr - ferr0), 32'd1);
        idle(CPB);
        send_frame(8'h11, 1'b1, 1'b0);
        drain_and_check("framing");

        // Overrun: five bytes into a four-deep FIFO
        rx_if.out_ready = 1'b0;
        ovr0 = seen_ovr;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        idle(5);
        check("ovr_count_full", 32'(rx_if.out_count), 32'd4);
        check("ovr_pulses",     32'(seen_ovr - ovr0), 32'd1);
        drain_and_check("overrun");

        // Push and pop in the same cycle while full
        rx_if.out_ready = 1'b0;
        ovr0 = seen_ovr;
        send_frame(8'h21, 1'b1, 1'b0);
        send_frame(8'h32, 1'b1, 1'b0);
        send_frame(8'h43, 1'b1, 1'b0);
        send_frame(8'h54, 1'b1, 1'b0);
        send_frame(8'h77, 1'b1, 1'b1);
        idle(3);
        check("pp_count",  32'(rx_if.out_count), 32'd4);
        check("pp_no_ovr", 32'(seen_ovr - ovr0), 32'd0);
        drain_and_check("pushpop");

        // Reset in the middle of data bit 3 with two bytes queued
        rx_if.out_ready = 1'b0;
        send_frame(8'h9C, 1'b1, 1'b0);
        send_frame(8'h3E, 1'b1, 1'b0);
        rb = 8'h00;
        in_rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            in_rx = rb[i];
            idle(CPB);
        end
        in_rx = 1'b0;
        idle(CPB / 2);
        reset = 1'b1;
        in_rx = 1'b1;
        exp_q.delete();
        idle(1);
        reset = 1'b0;
        check("rst_mid_valid", 32'(rx_if.out_valid), 32'd0);
        check("rst_mid_count", 32'(rx_if.out_count), 32'd0);
        idle(CPB * 12);
        rx_if.out_ready = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0);
        drain_and_check("reset_mid");

        // Randomized frames, stop-bit errors and consumer stalls
        for (int k = 0; k < 40; k++) begin
            rb    = 8'($urandom);
            rgood = ($urandom_range(0, 5) != 0);
            rx_if.out_ready = 1'($urandom_range(0, 1));
            send_frame(rb, rgood, 1'b0);
            gap = rgood ? $urandom_range(0, 20) : $urandom_range(CPB, 2 * CPB);
            if (gap > 0) idle(gap);
        end
        drain_and_check("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
